// File: rtl/stack_counter_register.sv
// Program-counter style register with a small return stack: increment, load,
// call (push return address, jump) and return (pop) with sticky overflow/underflow error.
module stack_counter_register #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic                     clock,
   input  logic                     clear_n,
   input  logic                     increment_signal,
   input  logic                     write_enable,
   input  logic                     call_enable,
   input  logic                     return_enable,
   input  logic                     error_clear,
   input  logic [WIDTH-1:0]         input_data,
   output logic [WIDTH-1:0]         output_data,
   output logic [$clog2(DEPTH):0]   stack_count,
   output logic                     stack_empty,
   output logic                     stack_full,
   output logic                     stack_error
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      OP_IDLE   = 3'd0,
      OP_CALL   = 3'd1,
      OP_RETURN = 3'd2,
      OP_WRITE  = 3'd3,
      OP_INC    = 3'd4
   } op_t;

   // Return addresses always wrap, whatever the increment mode is.
   function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
      return v + WIDTH'(1'b1);
   endfunction

   function automatic logic [WIDTH-1:0] mode_inc(input logic [WIDTH-1:0] v);
      if ((SATURATE != 0) && (v == {WIDTH{1'b1}})) begin
         return v;
      end else begin
         return wrap_inc(v);
      end
   endfunction

   logic [WIDTH-1:0] value;
   logic [CW-1:0]    count;
   logic             error_flag;
   logic [WIDTH-1:0] stack_mem [DEPTH];

   op_t              op;
   logic [WIDTH-1:0] value_next;
   logic [CW-1:0]    count_next;
   logic             error_next;
   logic             push_en;
   logic [PW-1:0]    push_idx;
   logic [PW-1:0]    top_idx;
   logic             is_empty;
   logic             is_full;

   assign push_idx = count[PW-1:0];
   assign top_idx  = push_idx - PW'(1'b1);
   assign is_empty = (count == CW'(0));
   assign is_full  = (count == CW'(DEPTH));

   // Single-operation priority decode: lower requests are simply dropped.
   always_comb begin
      op = OP_IDLE;
      if (call_enable) begin
         op = OP_CALL;
      end else if (return_enable) begin
         op = OP_RETURN;
      end else if (write_enable) begin
         op = OP_WRITE;
      end else if (increment_signal) begin
         op = OP_INC;
      end else begin
         op = OP_IDLE;
      end
   end

   // Next value, stack depth and error flag for the decoded operation.
   always_comb begin
      value_next = value;
      count_next = count;
      push_en    = 1'b0;
      error_next = error_flag & ~error_clear;
      case (op)
         OP_CALL: begin
            if (is_full) begin
               error_next = 1'b1;
            end else begin
               push_en    = 1'b1;
               count_next = count + CW'(1'b1);
               value_next = input_data;
            end
         end
         OP_RETURN: begin
            if (is_empty) begin
               error_next = 1'b1;
            end else begin
               count_next = count - CW'(1'b1);
               value_next = stack_mem[top_idx];
            end
         end
         OP_WRITE: begin
            value_next = input_data;
         end
         OP_INC: begin
            value_next = mode_inc(value);
         end
         default: begin
            value_next = value;
         end
      endcase
   end

   // Held value, depth and sticky error, asynchronously cleared.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         value      <= {WIDTH{1'b0}};
         count      <= {CW{1'b0}};
         error_flag <= 1'b0;
      end else begin
         value      <= value_next;
         count      <= count_next;
         error_flag <= error_next;
      end
   end

   // Stack storage has no reset; entries at or above the depth are never read.
   always_ff @(posedge clock) begin
      if (push_en) begin
         stack_mem[push_idx] <= wrap_inc(value);
      end
   end

   assign output_data = value;
   assign stack_count = count;
   assign stack_error = error_flag;
   assign stack_empty = is_empty;
   assign stack_full  = is_full;

endmodule

// File: tb/tb_stack_counter_register.sv
// Directed table-driven bench for stack_counter_register (wrap and saturate instances).
module tb_stack_counter_register;

   logic       clock = 1'b0;
   logic       clear_n;
   logic       increment_signal, write_enable, call_enable, return_enable, error_clear;
   logic [7:0] input_data;
   logic [7:0] out_w, out_s;
   logic [2:0] cnt_w, cnt_s;
   logic       empty_w, full_w, err_w, empty_s, full_s, err_s;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   stack_counter_register #(.WIDTH(8), .DEPTH(4), .SATURATE(0)) dut (
      .clock(clock), .clear_n(clear_n), .increment_signal(increment_signal),
      .write_enable(write_enable), .call_enable(call_enable), .return_enable(return_enable),
      .error_clear(error_clear), .input_data(input_data), .output_data(out_w),
      .stack_count(cnt_w), .stack_empty(empty_w), .stack_full(full_w), .stack_error(err_w));

   stack_counter_register #(.WIDTH(8), .DEPTH(4), .SATURATE(1)) dut_sat (
      .clock(clock), .clear_n(clear_n), .increment_signal(increment_signal),
      .write_enable(write_enable), .call_enable(call_enable), .return_enable(return_enable),
      .error_clear(error_clear), .input_data(input_data), .output_data(out_s),
      .stack_count(cnt_s), .stack_empty(empty_s), .stack_full(full_s), .stack_error(err_s));

   typedef struct {
      logic       call, ret, wr, inc, eclr;
      logic [7:0] din;
      logic [7:0] out;
      logic [7:0] sat_out;
      logic [2:0] cnt;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic r, input logic w, input logic i,
                        input logic e, input logic [7:0] d);
      call_enable = c; return_enable = r; write_enable = w;
      increment_signal = i; error_clear = e; input_data = d;
   endtask

   function automatic vec_t mk(input logic c, input logic r, input logic w, input logic i,
                               input logic e, input logic [7:0] d, input logic [7:0] o,
                               input logic [7:0] so, input logic [2:0] n, input logic er);
      vec_t v;
      v.call = c; v.ret = r; v.wr = w; v.inc = i; v.eclr = e; v.din = d;
      v.out = o; v.sat_out = so; v.cnt = n; v.err = er;
      return v;
   endfunction

   initial begin
      //            call ret wr  inc eclr din    out    sat    cnt  err
      vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h01, 8'h01, 3'd0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h02, 8'h02, 3'd0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h03, 8'h03, 3'd0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h10, 8'h10, 8'h10, 3'd0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h40, 8'h40, 8'h40, 3'd1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h80, 8'h80, 8'h80, 3'd2, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h41, 8'h41, 3'd1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h11, 8'h11, 3'd0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h22, 8'h22, 8'h22, 3'd0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h22, 8'h22, 3'd0, 1));  // return on empty
      vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h22, 8'h22, 3'd0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h07, 8'h07, 8'h07, 3'd0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 8'h55, 8'h55, 8'h55, 3'd1, 0));  // all requests: call wins
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h08, 8'h08, 3'd0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h01, 8'h01, 8'h01, 3'd1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h02, 8'h02, 8'h02, 3'd2, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h03, 8'h03, 8'h03, 3'd3, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h04, 8'h04, 8'h04, 3'd4, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'hAA, 8'h04, 8'h04, 3'd4, 1));  // call on full
      vecs.push_back(mk(1, 0, 0, 0, 1, 8'h11, 8'h04, 8'h04, 3'd4, 1));  // set beats clear
      vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h04, 8'h04, 3'd4, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 8'h77, 8'h04, 8'h04, 3'd3, 0));  // return beats write/inc
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h03, 8'h03, 3'd2, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 3'd2, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'hFF, 3'd2, 0));  // wrap vs saturate
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'h02, 8'h02, 3'd1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h02, 8'h02, 3'd1, 0));  // idle holds
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h09, 8'h09, 3'd0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 3'd0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 8'h33, 8'h33, 8'h33, 3'd1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0));  // pushed FF+1 wraps

      clear_n = 1'b0;
      drive(0, 0, 0, 0, 0, 8'h00);
      #12;
      check("reset_out", -1, 32'(out_w), 32'h00);
      check("reset_cnt", -1, 32'(cnt_w), 32'd0);
      check("reset_empty", -1, 32'(empty_w), 32'd1);
      check("reset_full", -1, 32'(full_w), 32'd0);
      check("reset_err", -1, 32'(err_w), 32'd0);
      clear_n = 1'b1;

      foreach (vecs[k]) begin
         drive(vecs[k].call, vecs[k].ret, vecs[k].wr, vecs[k].inc, vecs[k].eclr, vecs[k].din);
         @(posedge clock);
         #1;
         check("out", k, 32'(out_w), 32'(vecs[k].out));
         check("cnt", k, 32'(cnt_w), 32'(vecs[k].cnt));
         check("err", k, 32'(err_w), 32'(vecs[k].err));
         check("empty", k, 32'(empty_w), 32'(vecs[k].cnt == 3'd0));
         check("full", k, 32'(full_w), 32'(vecs[k].cnt == 3'd4));
         check("sat_out", k, 32'(out_s), 32'(vecs[k].sat_out));
      end

      // Build depth 3 with 8'h9A held, then pulse reset between edges.
      for (int j = 0; j < 3; j++) begin
         drive(1, 0, 0, 0, 0, 8'h50);
         @(posedge clock);
         #1;
      end
      drive(0, 0, 1, 0, 0, 8'h9A);
      @(posedge clock);
      #1;
      check("pre_rst_out", 100, 32'(out_w), 32'h9A);
      check("pre_rst_cnt", 100, 32'(cnt_w), 32'd3);
      drive(1, 0, 0, 0, 0, 8'h66);
      #2;
      clear_n = 1'b0;
      #1;
      check("async_out", 101, 32'(out_w), 32'h00);
      check("async_cnt", 101, 32'(cnt_w), 32'd0);
      check("async_empty", 101, 32'(empty_w), 32'd1);
      check("async_sat_cnt", 101, 32'(cnt_s), 32'd0);
      @(posedge clock);
      #1;
      check("rst_hold_out", 102, 32'(out_w), 32'h00);
      check("rst_hold_cnt", 102, 32'(cnt_w), 32'd0);
      drive(0, 0, 0, 1, 0, 8'h00);
      clear_n = 1'b1;
      @(posedge clock);
      #1;
      check("first_op_out", 103, 32'(out_w), 32'h01);
      check("first_op_cnt", 103, 32'(cnt_w), 32'd0);
      check("first_op_err", 103, 32'(err_s), 32'd0);
      check("first_op_full", 103, 32'(full_s), 32'd0);
      check("first_op_empty", 103, 32'(empty_s), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/stack_counter_register.md
STACK_COUNTER_REGISTER -- requirements
Module: stack_counter_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data/counter width in bits (>=2).
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of return-stack entries (power of two, >=2).
REQ-003 The block SHALL have parameter SATURATE, default 0; 0 = increment wraps, 1 = increment holds at all-ones.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 clear_n  input  1  asynchronous, active-low reset.
REQ-006 increment_signal  input  1  add 1 to the held value.
REQ-007 write_enable  input  1  load input_data into the held value.
REQ-008 call_enable  input  1  push (held value + 1) onto the stack and load input_data.
REQ-009 return_enable  input  1  pop the stack top into the held value.
REQ-010 error_clear  input  1  synchronous clear of stack_error.
REQ-011 input_data  input  WIDTH  load/call target value.
REQ-012 output_data  output  WIDTH  held value, driven directly from the register.
REQ-013 stack_count  output  clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
REQ-014 stack_empty  output  1  high when stack_count == 0.
REQ-015 stack_full  output  1  high when stack_count == DEPTH.
REQ-016 stack_error  output  1  sticky flag: call on full or return on empty was attempted.

Function
REQ-017 One operation SHALL execute per cycle, priority call_enable > return_enable > write_enable > increment_signal; lower-priority requests in the same cycle SHALL be ignored, not queued.
REQ-018 With no request asserted, output_data, stack contents and stack_count SHALL hold.
REQ-019 All results SHALL appear on output_data and flags one cycle after the sampling edge (registered, latency 1).
REQ-020 Call, stack not full: stack[stack_count] <= output_data+1 (mod 2^WIDTH, regardless of SATURATE), stack_count+1, output_data <= input_data.
REQ-021 Call, stack full: output_data, stack and stack_count SHALL be unchanged; stack_error SHALL be set.
REQ-022 Return, stack not empty: output_data <= stack[stack_count-1], stack_count-1.
REQ-023 Return, stack empty: output_data and stack_count SHALL be unchanged; stack_error SHALL be set.
REQ-024 Write: output_data <= input_data; stack untouched.
REQ-025 Increment, SATURATE=0: output_data <= output_data+1, all-ones wraps to 0.
REQ-026 Increment, SATURATE=1: all-ones SHALL remain all-ones; otherwise +1.
REQ-027 stack_error SHALL remain set until error_clear or reset; if error_clear coincides with a new error condition, set SHALL win.
REQ-028 error_clear SHALL not affect output_data, stack or stack_count.
REQ-029 Stack entries above stack_count are don't-care and SHALL never be observable on output_data.
REQ-030 stack_empty and stack_full SHALL be derived combinationally from stack_count only.

Reset
REQ-031 clear_n low SHALL immediately, without a clock edge, force output_data=0, stack_count=0, stack_error=0 (stack_empty=1, stack_full=0).
REQ-032 Reset asserted mid-operation SHALL discard any request sampled in that cycle; stack entry contents need not be cleared.
REQ-033 First operation SHALL be accepted on the first rising edge with clear_n high.

Verification
REQ-034 Reset, then 3x increment_signal -> output_data 0,1,2,3; WIDTH=8 from 8'hFF increment -> 8'h00 (SATURATE=0), 8'hFF (SATURATE=1).
REQ-035 write 8'h10, call input 8'h40, call input 8'h80, return, return -> output_data 10,40,80,41,11; stack_count 0,1,2,1,0.
REQ-036 DEPTH=4: 4 calls -> stack_full=1; 5th call -> output_data unchanged, stack_error=1; error_clear -> stack_error=0.
REQ-037 Return on empty stack with output_data=8'h22 -> output_data 8'h22, stack_error=1, stack_count 0.
REQ-038 call_enable+return_enable+write_enable+increment_signal same cycle, input 8'h55, output 8'h07 -> call only: output 8'h55, pushed 8'h08.
REQ-039 clear_n pulsed low between clock edges with stack_count=3, output 8'h9A -> output_data 0, stack_count 0, stack_empty 1 before next edge.
